// File: rtl/acia.sv
// acia: memory-mapped 8N1 console UART with a 6850-style register pair.
// Ports: CLK0/reset_n (sync, active low), pclk bit-timing enable, bus (cs_n, we_n, rs, din, dout),
//        serial rx/tx, irq_n. dout is registered (valid one cycle after the address); no backpressure.
module acia #(
   parameter int clk_freq = 3333333,
   parameter int baudrate = 115200
) (
   input  logic       CLK0,
   input  logic       reset_n,
   input  logic       pclk,
   input  logic       cs_n,
   input  logic       we_n,
   input  logic       rs,
   input  logic       rx,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       tx,
   output logic       irq_n
);
   localparam int DIV  = (clk_freq + baudrate / 2) / baudrate;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic [7:0]    ctrl_q, ctrl_d;
   logic [7:0]    dout_q, dout_d;
   logic          tx_q, tx_d;
   logic          irq_n_q, irq_n_d;
   logic          rdrf_q, rdrf_d;
   logic          tdre_q, tdre_d;
   logic          fe_q, fe_d;
   logic          ovrn_q, ovrn_d;
   logic [7:0]    rx_hold_q, rx_hold_d;
   logic [8:0]    tx_sr_q, tx_sr_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic          rx_s1_q, rx_s1_d;
   logic          rx_s2_q, rx_s2_d;
   logic [1:0]    rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sr_q, rx_sr_d;
   logic          rx_armed_q, rx_armed_d;

   logic          wr, rd, soft_rst, rx_done;
   logic [7:0]    status;

   always_comb begin
      ctrl_d     = ctrl_q;
      tx_d       = tx_q;
      rdrf_d     = rdrf_q;
      tdre_d     = tdre_q;
      fe_d       = fe_q;
      ovrn_d     = ovrn_q;
      rx_hold_d  = rx_hold_q;
      tx_sr_d    = tx_sr_q;
      tx_bit_d   = tx_bit_q;
      tx_cnt_d   = tx_cnt_q;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sr_d    = rx_sr_q;
      rx_armed_d = rx_armed_q;
      rx_done    = 1'b0;

      wr       = ~cs_n & ~we_n;
      rd       = ~cs_n & we_n;
      soft_rst = wr & ~rs & (din[1:0] == 2'b11);

      rx_s1_d = rx;
      rx_s2_d = rx_s1_q;

      // dout reloads every edge regardless of cs_n
      status  = {~irq_n_q, 1'b0, ovrn_q, fe_q, 2'b00, tdre_q, rdrf_q};
      dout_d  = rs ? rx_hold_q : status;
      irq_n_d = ~((ctrl_q[7] & rdrf_q) | (ctrl_q[5] & tdre_q));

      if (wr & ~rs)
         ctrl_d = din;

      if (rd & rs) begin
         rdrf_d = 1'b0;
         fe_d   = 1'b0;
         ovrn_d = 1'b0;
      end

      // Transmitter: tx_sr holds {stop, data}; the start bit is driven at load time.
      if (!tdre_q) begin
         if (pclk) begin
            if (tx_cnt_q == DIV_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 4'd9) begin
                  tdre_d = 1'b1;
                  tx_d   = 1'b1;
               end else begin
                  tx_d     = tx_sr_q[0];
                  tx_sr_d  = {1'b1, tx_sr_q[8:1]};
                  tx_bit_d = tx_bit_q + 4'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
      end else if (wr & rs) begin
         tx_sr_d  = {1'b1, din};
         tx_d     = 1'b0;
         tdre_d   = 1'b0;
         tx_bit_d = '0;
         tx_cnt_d = '0;
      end

      // Receiver: rx_armed prevents a low stop bit (framing error) from
      // being taken as the next start bit.
      if (pclk) begin
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_s2_q) begin
                  rx_armed_d = 1'b1;
               end else if (rx_armed_q) begin
                  rx_state_d = RX_START;
                  rx_cnt_d   = '0;
                  rx_armed_d = 1'b0;
               end
            end
            RX_START: begin
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_d = '0;
                  rx_bit_d = '0;
                  rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == DIV_LAST) begin
                  rx_cnt_d = '0;
                  rx_sr_d  = {rx_s2_q, rx_sr_q[7:1]};
                  if (rx_bit_q == 3'd7)
                     rx_state_d = RX_STOP;
                  else
                     rx_bit_d = rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end
            end
            default: begin
               if (rx_cnt_q == DIV_LAST) begin
                  rx_cnt_d   = '0;
                  rx_state_d = RX_IDLE;
                  rx_done    = 1'b1;
               end else begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end
            end
         endcase
      end

      // A data read on the completion edge frees the holding register, so the new byte wins.
      if (rx_done) begin
         if (!rdrf_q || (rd & rs)) begin
            rx_hold_d = rx_sr_q;
            rdrf_d    = 1'b1;
            fe_d      = ~rx_s2_q;
         end else begin
            ovrn_d = 1'b1;
         end
      end

      if (soft_rst) begin
         ctrl_d     = 8'h00;
         dout_d     = 8'h00;
         tx_d       = 1'b1;
         irq_n_d    = 1'b1;
         rdrf_d     = 1'b0;
         tdre_d     = 1'b1;
         fe_d       = 1'b0;
         ovrn_d     = 1'b0;
         tx_bit_d   = '0;
         tx_cnt_d   = '0;
         rx_state_d = RX_IDLE;
         rx_cnt_d   = '0;
         rx_bit_d   = '0;
         rx_armed_d = 1'b0;
      end
   end

   always_ff @(posedge CLK0) begin
      if (!reset_n) begin
         ctrl_q     <= 8'h00;
         dout_q     <= 8'h00;
         tx_q       <= 1'b1;
         irq_n_q    <= 1'b1;
         rdrf_q     <= 1'b0;
         tdre_q     <= 1'b1;
         fe_q       <= 1'b0;
         ovrn_q     <= 1'b0;
         rx_hold_q  <= 8'h00;
         tx_sr_q    <= '1;
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sr_q    <= 8'h00;
         rx_armed_q <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         dout_q     <= dout_d;
         tx_q       <= tx_d;
         irq_n_q    <= irq_n_d;
         rdrf_q     <= rdrf_d;
         tdre_q     <= tdre_d;
         fe_q       <= fe_d;
         ovrn_q     <= ovrn_d;
         rx_hold_q  <= rx_hold_d;
         tx_sr_q    <= tx_sr_d;
         tx_bit_q   <= tx_bit_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_s1_q    <= rx_s1_d;
         rx_s2_q    <= rx_s2_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sr_q    <= rx_sr_d;
         rx_armed_q <= rx_armed_d;
      end
   end

   assign dout  = dout_q;
   assign tx    = tx_q;
   assign irq_n = irq_n_q;

endmodule

// File: tb/tb_acia.sv
// tb_acia: scenario tasks for the acia console UART, checked against a register-level model.
// Ports: none; drives CLK0, reset_n, a free-running pclk (one pulse per 3 clocks), bus and rx.
module tb_acia;
   localparam int DIV = 29;

   logic       CLK0 = 1'b0;
   logic       reset_n = 1'b0;
   logic       pclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       we_n = 1'b1;
   logic       rs = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       tx;
   logic       irq_n;

   int errors = 0;
   int checks = 0;
   bit pclk_en = 1'b1;
   int pcnt = 0;

   // reference model of the programmer-visible state
   bit         m_rdrf, m_fe, m_ovrn, m_tdre, m_rie, m_tie;
   logic [7:0] m_hold;

   acia #(.clk_freq(3333333), .baudrate(115200)) dut (
      .CLK0(CLK0), .reset_n(reset_n), .pclk(pclk), .cs_n(cs_n), .we_n(we_n),
      .rs(rs), .rx(rx), .din(din), .dout(dout), .tx(tx), .irq_n(irq_n)
   );

   always #5 CLK0 = ~CLK0;

   initial begin
      forever begin
         @(negedge CLK0);
         pcnt++;
         pclk = pclk_en && (pcnt % 3 == 0);
      end
   end

   function automatic logic [7:0] m_status();
      bit irq;
      irq = (m_rie & m_rdrf) | (m_tie & m_tdre);
      return {irq, 1'b0, m_ovrn, m_fe, 2'b00, m_tdre, m_rdrf};
   endfunction

   task automatic m_reset();
      m_rdrf = 0; m_fe = 0; m_ovrn = 0; m_tdre = 1; m_rie = 0; m_tie = 0;
   endtask

   task automatic m_rx_frame(input logic [7:0] b, input bit stop);
      if (!m_rdrf) begin
         m_hold = b; m_rdrf = 1; m_fe = !stop;
      end else begin
         m_ovrn = 1;
      end
   endtask

   task automatic m_data_read(output logic [7:0] v);
      v = m_hold; m_rdrf = 0; m_fe = 0; m_ovrn = 0;
   endtask

   // Advance to the point just before the next CLK0 edge that carries a pclk pulse.
   task automatic next_pulse();
      int guard = 0;
      do begin
         @(negedge CLK0); #1;
         guard++;
      end while (!pclk && guard < 100);
      if (!pclk) begin
         checks++; errors++;
         $display("FAIL pclk_timeout: no pclk pulse within 100 cycles");
      end
   endtask

   task automatic bus_write(input logic r, input logic [7:0] d);
      @(negedge CLK0); #1;
      cs_n = 0; we_n = 0; rs = r; din = d;
      @(posedge CLK0); #1;
      cs_n = 1; we_n = 1;
   endtask

   task automatic bus_read(input logic r, output logic [7:0] d);
      @(negedge CLK0); #1;
      cs_n = 0; we_n = 1; rs = r;
      @(posedge CLK0); #1;
      d = dout;
      cs_n = 1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (DIV) next_pulse();
      end
      rx = 1;
      m_rx_frame(b, stop);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset_n = 0;
      repeat (5) @(posedge CLK0);
      #1;
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %02h expected 00", dout); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b expected 1", irq_n); end
      @(negedge CLK0); reset_n = 1;
      m_reset();
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL reset_status: got %02h expected %02h", d, m_status()); end
   endtask

   task automatic test_tx(input logic [7:0] b, input bit mid);
      logic [9:0] fr;
      logic [7:0] d;
      bit bad;
      fr = {1'b1, b, 1'b0};
      bus_write(1, b);
      m_tdre = 0;
      for (int bi = 0; bi < 10; bi++) begin
         bad = 0;
         for (int k = 0; k < DIV; k++) begin
            next_pulse();
            if (tx !== fr[bi]) bad = 1;
            if (mid && bi == 4 && k == 10) begin
               bus_read(0, d);
               checks++; if (d !== m_status()) begin errors++; $display("FAIL tx_busy_status: got %02h expected %02h", d, m_status()); end
               bus_write(1, ~b);   // must be ignored while busy
            end
         end
         checks++;
         if (bad) begin errors++; $display("FAIL tx_bit%0d of %02h: tx not %b for all %0d pulses", bi, b, fr[bi], DIV); end
      end
      @(posedge CLK0); #1;
      m_tdre = 1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b expected 1", tx); end
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL tx_done_status: got %02h expected %02h", d, m_status()); end
   endtask

   task automatic test_rx_basic();
      logic [7:0] d, e;
      send_frame(8'hA5, 1);
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL rx_status: got %02h expected %02h", d, m_status()); end
      bus_read(1, d); m_data_read(e);
      checks++; if (d !== e) begin errors++; $display("FAIL rx_data: got %02h expected %02h", d, e); end
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL rx_after_read: got %02h expected %02h", d, m_status()); end
   endtask

   task automatic test_irq();
      logic [7:0] d, e;
      bus_write(0, 8'h80); m_rie = 1;
      send_frame(8'h3C, 1);
      repeat (2) @(posedge CLK0);
      #1;
      checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL irq_rie_low: got %b expected 0", irq_n); end
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL irq_status: got %02h expected %02h", d, m_status()); end
      bus_read(1, d); m_data_read(e);
      checks++; if (d !== e) begin errors++; $display("FAIL irq_data: got %02h expected %02h", d, e); end
      repeat (2) @(posedge CLK0);
      #1;
      checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_rie_release: got %b expected 1", irq_n); end
      bus_write(0, 8'h20); m_rie = 0; m_tie = 1;
      repeat (2) @(posedge CLK0);
      #1;
      checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL irq_tie_low: got %b expected 0", irq_n); end
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL irq_tie_status: got %02h expected %02h", d, m_status()); end
      bus_write(0, 8'h00); m_tie = 0;
      repeat (2) @(posedge CLK0);
      #1;
      checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_off: got %b expected 1", irq_n); end
   endtask

   task automatic test_overrun();
      logic [7:0] d, e;
      send_frame(8'h11, 1);
      send_frame(8'h22, 1);
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL ovrn_status: got %02h expected %02h", d, m_status()); end
      bus_read(1, d); m_data_read(e);
      checks++; if (d !== e) begin errors++; $display("FAIL ovrn_data: got %02h expected %02h", d, e); end
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL ovrn_cleared: got %02h expected %02h", d, m_status()); end
   endtask

   task automatic test_false_start();
      logic [7:0] d;
      rx = 0;
      repeat (10) next_pulse();
      rx = 1;
      repeat (3 * DIV) next_pulse();
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL false_start: got %02h expected %02h", d, m_status()); end
   endtask

   task automatic test_framing();
      logic [7:0] d, e, b;
      b = 8'($urandom);
      send_frame(b, 0);
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL fe_status: got %02h expected %02h", d, m_status()); end
      bus_read(1, d); m_data_read(e);
      checks++; if (d !== e) begin errors++; $display("FAIL fe_data: got %02h expected %02h", d, e); end
   endtask

   task automatic test_soft_reset();
      logic [7:0] d;
      bus_write(0, 8'hA0);
      bus_write(1, 8'h00);
      repeat (40) next_pulse();
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL srst_tx_busy: got %b expected 0", tx); end
      bus_write(0, 8'h03);
      m_reset();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL srst_tx: got %b expected 1", tx); end
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL srst_status: got %02h expected %02h", d, m_status()); end
      repeat (2 * DIV) next_pulse();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL srst_tx_hold: got %b expected 1", tx); end
   endtask

   task automatic test_no_pclk();
      logic [7:0] d;
      pclk_en = 0;
      repeat (4) @(posedge CLK0);
      bus_write(1, 8'h81); m_tdre = 0;
      repeat (300) @(posedge CLK0);
      #1;
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL nopclk_tx: got %b expected 0", tx); end
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL nopclk_status: got %02h expected %02h", d, m_status()); end
      bus_write(0, 8'h03); m_reset();
      pclk_en = 1;
      bus_read(0, d);
      checks++; if (d !== m_status()) begin errors++; $display("FAIL nopclk_recover: got %02h expected %02h", d, m_status()); end
   endtask

   task automatic test_random();
      logic [7:0] d, e, b;
      bit stop;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send_frame(b, stop);
         bus_read(0, d);
         checks++; if (d !== m_status()) begin errors++; $display("FAIL rand_status%0d: got %02h expected %02h", i, d, m_status()); end
         if ($urandom_range(0, 1) == 1) begin
            bus_read(1, d); m_data_read(e);
            checks++; if (d !== e) begin errors++; $display("FAIL rand_data%0d: got %02h expected %02h", i, d, e); end
         end
      end
      bus_read(1, d); m_data_read(e);
      checks++; if (d !== e) begin errors++; $display("FAIL rand_drain: got %02h expected %02h", d, e); end
   endtask

   task automatic test_back_to_back();
      test_tx(8'($urandom), 0);
      test_tx(8'($urandom), 1);
   endtask

   initial begin
      m_reset();
      m_hold = 8'h00;
      test_reset();
      test_tx(8'h55, 1);
      test_rx_basic();
      test_irq();
      test_overrun();
      test_false_start();
      test_framing();
      test_soft_reset();
      test_no_pclk();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
